// File: rtl/mips_mem_pkg.sv
// Shared definitions for the L1 line-transfer path: FSM states and line geometry.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDone
    } line_state_e;

    localparam int unsigned LINE_W   = 128;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned OFFSET_W = 4;

endpackage

// File: rtl/mem_line_ctrl.sv
// Moves one 128-bit cache line to/from 32-bit memory as four handshaked word beats.
// Every output is registered; busy covers the whole transfer including the DONE cycle.
module mem_line_ctrl #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [127:0]      wr_line,
    output logic              busy,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [127:0]      fill_line,
    output logic              wr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);
    import mips_mem_pkg::*;

    localparam logic [1:0] LastBeat = 2'(BEATS - 1);

    line_state_e       state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [LINE_W-1:0] wbuf_q, wbuf_d;
    logic [LINE_W-1:0] rbuf_q, rbuf_d;
    logic              busy_q, busy_d;
    logic              fill_valid_q, fill_valid_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    logic              wr_done_q, wr_done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        beat_nxt;

    // Byte offset within the line is never used.
    logic unused_offset;
    assign unused_offset = ^{rd_addr[OFFSET_W-1:0], wr_addr[OFFSET_W-1:0]};

    assign beat_nxt = beat_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_addr_d  = line_addr_q;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        busy_d       = busy_q;
        fill_valid_d = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_line_d  = fill_line_q;
        wr_done_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (wr_req) begin
                    state_d     = StWrite;
                    beat_d      = 2'd0;
                    line_addr_d = {wr_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    wbuf_d      = wr_line;
                    busy_d      = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {wr_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    mem_wdata_d = wr_line[WORD_W-1:0];
                end else if (rd_req) begin
                    state_d     = StRead;
                    beat_d      = 2'd0;
                    line_addr_d = {rd_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    busy_d      = 1'b1;
                    mem_re_d    = 1'b1;
                    mem_addr_d  = {rd_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    if (beat_q == LastBeat) begin
                        state_d   = StDone;
                        mem_we_d  = 1'b0;
                        wr_done_d = 1'b1;
                    end else begin
                        beat_d      = beat_nxt;
                        mem_addr_d  = {line_addr_q[ADDR_W-1:OFFSET_W], beat_nxt, 2'b00};
                        mem_wdata_d = wbuf_q[{beat_nxt, 5'b0} +: WORD_W];
                    end
                end
            end
            StRead: begin
                if (mem_ready) begin
                    rbuf_d[{beat_q, 5'b0} +: WORD_W] = mem_rdata;
                    if (beat_q == LastBeat) begin
                        state_d      = StDone;
                        mem_re_d     = 1'b0;
                        fill_valid_d = 1'b1;
                        fill_addr_d  = line_addr_q;
                        fill_line_d  = rbuf_d;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = {line_addr_q[ADDR_W-1:OFFSET_W], beat_nxt, 2'b00};
                    end
                end
            end
            StDone: begin
                // Requests are ignored here so the requester can drop its level.
                state_d = StIdle;
                beat_d  = 2'd0;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            beat_q       <= 2'd0;
            line_addr_q  <= '0;
            wbuf_q       <= '0;
            rbuf_q       <= '0;
            busy_q       <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_line_q  <= '0;
            wr_done_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            line_addr_q  <= line_addr_d;
            wbuf_q       <= wbuf_d;
            rbuf_q       <= rbuf_d;
            busy_q       <= busy_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_line_q  <= fill_line_d;
            wr_done_q    <= wr_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy       = busy_q;
    assign fill_valid = fill_valid_q;
    assign fill_addr  = fill_addr_q;
    assign fill_line  = fill_line_q;
    assign wr_done    = wr_done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl: memory model plus a beat scoreboard.
module tb_mem_line_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req, wr_req, mem_ready, mem_clear;
    logic [31:0]  rd_addr, wr_addr;
    logic [127:0] wr_line;
    logic         busy, fill_valid, wr_done, mem_re, mem_we;
    logic [31:0]  fill_addr, mem_addr, mem_wdata, mem_rdata;
    logic [127:0] fill_line;

    logic [31:0]   mem_arr [0:4095];
    logic [4095:0] mem_wvalid;

    beat_t sb_q[$];
    int    vectors    = 0;
    int    miscompares = 0;

    mem_line_ctrl #(.BEATS(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_line   (wr_line),
        .busy      (busy),
        .fill_valid(fill_valid),
        .fill_addr (fill_addr),
        .fill_line (fill_line),
        .wr_done   (wr_done),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a[15:4] == 12'h123) return 32'hA0 + {30'b0, a[3:2]};
        return {a[15:0], 16'h5A5A};
    endfunction

    // Backing memory: unwritten words return an address-derived pattern.
    assign mem_rdata = mem_wvalid[mem_addr[13:2]] ? mem_arr[mem_addr[13:2]] : pat(mem_addr);

    always @(posedge clk) begin
        if (mem_clear) mem_wvalid <= '0;
        else if (mem_we && mem_ready) begin
            mem_arr[mem_addr[13:2]]    <= mem_wdata;
            mem_wvalid[mem_addr[13:2]] <= 1'b1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Pops one scoreboard entry whenever a beat completes in the current cycle.
    task automatic check_beat(input string name);
        beat_t e;
        logic [31:0] d;
        if ((mem_re || mem_we) && mem_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s extra beat: addr=%h we=%b, none expected", name, mem_addr,
                         mem_we);
            end else begin
                e = sb_q.pop_front();
                d = mem_we ? mem_wdata : 32'h0;
                if (mem_we !== e.we || mem_re !== !e.we || mem_addr !== e.addr || d !== e.data)
                begin
                    miscompares++;
                    $display("FAIL %s beat: got we=%b re=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                             name, mem_we, mem_re, mem_addr, d, e.we, e.addr, e.data);
                end
            end
        end
        vectors++;
        if (mem_re && mem_we) begin
            miscompares++;
            $display("FAIL %s strobes: re and we both high", name);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_clear = 1'b1;
        rd_req = 0; wr_req = 0; mem_ready = 0;
        rd_addr = 0; wr_addr = 0; wr_line = 0;
        step; step;
        mem_clear = 1'b0;
        vectors++;
        if ({busy, fill_valid, wr_done, mem_re, mem_we} !== 5'b0 || mem_addr !== 0 ||
            mem_wdata !== 0 || fill_addr !== 0 || fill_line !== 0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b fv=%b wd=%b re=%b we=%b addr=%h wdata=%h fa=%h fl=%h, want all 0",
                     busy, fill_valid, wr_done, mem_re, mem_we, mem_addr, mem_wdata, fill_addr,
                     fill_line);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_read;
        int fk = 0;
        rd_addr = 32'h0000_1234; rd_req = 1; mem_ready = 1;
        for (int k = 0; k < 4; k++) sb_q.push_back('{1'b0, 32'h1230 + 32'(4 * k), 32'h0});
        for (int k = 1; k <= 20 && fk == 0; k++) begin
            step;
            check_beat("read");
            if (fill_valid) begin fk = k; rd_req = 0; end
        end
        vectors++;
        if (fk != 5 || fill_addr !== 32'h1230 ||
            fill_line !== {32'hA3, 32'hA2, 32'hA1, 32'hA0} || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL read_fill: cycle=%0d addr=%h line=%h left=%0d, want cycle=5 addr=1230 line=a3a2a1a0 left=0",
                     fk, fill_addr, fill_line, sb_q.size());
        end
        step;
        vectors++;
        if (busy !== 1'b0 || fill_valid !== 1'b0 || fill_line !== {32'hA3, 32'hA2, 32'hA1, 32'hA0})
        begin
            miscompares++;
            $display("FAIL read_idle: busy=%b fv=%b line=%h, want busy=0 fv=0 line held", busy,
                     fill_valid, fill_line);
        end
        sb_q.delete();
    endtask

    task automatic test_write;
        int dk = 0, we_cnt = 0;
        logic re_seen = 0;
        wr_addr = 32'h80; wr_line = {32'hD, 32'hC, 32'hB, 32'hA}; wr_req = 1; mem_ready = 1;
        for (int k = 0; k < 4; k++) sb_q.push_back('{1'b1, 32'h80 + 32'(4 * k), 32'(10 + k)});
        for (int k = 1; k <= 20 && dk == 0; k++) begin
            step;
            check_beat("write");
            if (mem_re) re_seen = 1;
            if (mem_we) we_cnt++;
            if (wr_done) begin dk = k; wr_req = 0; end
        end
        vectors++;
        if (dk != 5 || we_cnt != 4 || re_seen !== 1'b0 || busy !== 1'b1 || sb_q.size() != 0)
        begin
            miscompares++;
            $display("FAIL write_done: cycle=%0d we_cycles=%0d re_seen=%b busy=%b left=%0d, want 5 4 0 1 0",
                     dk, we_cnt, re_seen, busy, sb_q.size());
        end
        step;
        vectors++;
        if (busy !== 1'b0 || wr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL write_idle: busy=%b wr_done=%b, want 0 0", busy, wr_done);
        end
        sb_q.delete();
    endtask

    task automatic test_back_to_back;
        int dk = 0, fk = 0, acc_k = 0;
        logic [127:0] line = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        wr_addr = 32'h2008; wr_line = line; wr_req = 1;
        rd_addr = 32'h200C; rd_req = 1; mem_ready = 1;
        for (int k = 0; k < 4; k++) sb_q.push_back('{1'b1, 32'h2000 + 32'(4 * k), line[32*k +: 32]});
        for (int k = 0; k < 4; k++) sb_q.push_back('{1'b0, 32'h2000 + 32'(4 * k), 32'h0});
        for (int k = 1; k <= 30 && fk == 0; k++) begin
            step;
            check_beat("wr_rd");
            if (wr_done) begin dk = k; wr_req = 0; end
            if (mem_re && acc_k == 0) acc_k = k - 1;
            if (fill_valid) begin fk = k; rd_req = 0; end
        end
        vectors++;
        if (dk != 5 || acc_k != 6 || fk != 11) begin
            miscompares++;
            $display("FAIL wr_rd_timing: wr_done=%0d rd_accept=%0d fill=%0d, want 5 6 11", dk,
                     acc_k, fk);
        end
        vectors++;
        if (fill_line !== line || fill_addr !== 32'h2000 || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL wr_rd_data: line=%h addr=%h left=%0d, want line=%h addr=2000 left=0",
                     fill_line, fill_addr, sb_q.size(), line);
        end
        step;
        sb_q.delete();
    endtask

    task automatic test_read_stall;
        int fk = 0, busy_cnt = 0, hold_cnt = 0;
        rd_addr = 32'h1230; rd_req = 1; mem_ready = 1;
        for (int k = 0; k < 4; k++) sb_q.push_back('{1'b0, 32'h1230 + 32'(4 * k), 32'h0});
        for (int k = 1; k <= 20 && fk == 0; k++) begin
            step;
            mem_ready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            check_beat("stall");
            if (busy) busy_cnt++;
            if (mem_re && mem_addr == 32'h1234) hold_cnt++;
            if (fill_valid) begin fk = k; rd_req = 0; end
        end
        step;
        mem_ready = 1;
        vectors++;
        if (fk != 7 || busy_cnt != 7 || hold_cnt != 3 || busy !== 1'b0 ||
            fill_line !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            miscompares++;
            $display("FAIL stall_read: fill=%0d busy_cycles=%0d hold=%0d busy_after=%b line=%h, want 7 7 3 0 a3a2a1a0",
                     fk, busy_cnt, hold_cnt, busy, fill_line);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid;
        int fk = 0;
        logic fv_seen = 0;
        rd_addr = 32'h3000; rd_req = 1; mem_ready = 1;
        for (int k = 1; k <= 3; k++) step;
        vectors++;
        if (mem_addr !== 32'h3008 || mem_re !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_beat2: addr=%h re=%b, want 3008 1", mem_addr, mem_re);
        end
        reset = 1; rd_req = 0;
        step;
        reset = 0;
        vectors++;
        if (busy !== 1'b0 || mem_re !== 1'b0 || fill_line !== 128'h0 || fill_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_state: busy=%b re=%b fv=%b line=%h, want 0 0 0 0", busy,
                     mem_re, fill_valid, fill_line);
        end
        rd_req = 1;
        for (int k = 0; k < 4; k++) sb_q.push_back('{1'b0, 32'h3000 + 32'(4 * k), 32'h0});
        for (int k = 1; k <= 20 && fk == 0; k++) begin
            step;
            check_beat("restart");
            if (fill_valid) begin fk = k; rd_req = 0; end
        end
        vectors++;
        if (fk != 5 || fill_line !== {pat(32'h300C), pat(32'h3008), pat(32'h3004), pat(32'h3000)}
            || sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_restart: fill=%0d line=%h left=%0d, want fill=5 clean line", fk,
                     fill_line, sb_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            step;
            if (fill_valid) fv_seen = 1;
        end
        vectors++;
        if (fv_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_extra_fill: fill_valid=1 seen, want 0");
        end
        sb_q.delete();
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_back_to_back;
        test_read_stall;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Line-transfer controller between the L1 cache's miss/write-through port and the 32-bit backing memory. It accepts a 128-bit write-through line or a line-refill request and performs a four-beat word transfer with per-beat ready handshakes. Refills are returned to the cache as one assembled 128-bit line. A registered busy flag feeds the hazard unit as the stall source for the whole transfer.

## Interface
- `BEATS`, default 4: words per line. The line is 128 bits, so the value is fixed at 4.
- `ADDR_W`, default 32: byte address width.
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high; all state is cleared on the rising edge of `clk` while it is high
- `rd_req`  in  1  refill request level; the requester holds it until `fill_valid`
- `rd_addr`  in  32  miss byte address; bits [3:0] are ignored
- `wr_req`  in  1  write-through request level; the requester holds it until `wr_done`
- `wr_addr`  in  32  write byte address; bits [3:0] are ignored
- `wr_line`  in  128  line to write; word k is bits [32k+31:32k]
- `busy`  out  1  stall to the hazard unit
- `fill_valid`  out  1  one-cycle pulse; `fill_line` and `fill_addr` are valid in this cycle
- `fill_addr`  out  32  line-aligned address of the refill
- `fill_line`  out  128  assembled refill line
- `wr_done`  out  1  one-cycle pulse when the write-through completes
- `mem_addr`  out  32  word address of the current beat
- `mem_re` / `mem_we`  out  1 each  beat strobes; never both high in the same cycle
- `mem_wdata`  out  32  write beat data
- `mem_rdata`  in  32  read beat data; sampled only when `mem_re` and `mem_ready` are both high
- `mem_ready`  in  1  completes the current beat

## Operation
- FSM states:
  - IDLE: waits for a request.
  - WRITE: performs the write-through beats.
  - READ: performs the refill beats.
  - DONE: lasts one cycle and issues the completion pulse.
- Requests are sampled only in IDLE.
  - `wr_req` has priority over `rd_req` when both are high. The held `rd_req` is then serviced after the write completes, so a refill of the same line returns the new data.
- On acceptance, the line address `{addr[31:4],4'b0}` and `wr_line` are latched, and the beat counter is cleared.
- Beat k drives `mem_addr = {line[31:4], k[1:0], 2'b00}`.
  - In WRITE, `mem_wdata` is latched word k.
  - In READ, `mem_rdata` is stored into word k of the line buffer.
- The strobe stays high for the whole WRITE/READ state.
  - The beat counter advances on each cycle with `mem_ready` = 1.
  - After beat 3 completes, the FSM moves to DONE.
- DONE:
  - If the transfer was a READ, `fill_valid` = 1, `fill_addr` = the latched line address, and `fill_line` = the buffer.
  - If it was a WRITE, `wr_done` = 1.
  - `busy` stays high in DONE and requests are ignored, which gives the requester one cycle to drop its request.
  - The next state is IDLE.
- `mem_ready` is ignored when no strobe is high.
- Reset values:
  - state IDLE and the beat counter is 0.
  - `busy`, `fill_valid`, `wr_done`, `mem_re`, `mem_we` are 0.
  - `mem_addr`, `mem_wdata`, `fill_addr`, `fill_line` are 0.
- Reset mid-transfer: the FSM returns to IDLE, the in-flight beat is abandoned, and no completion pulse is issued.
- Beat counter: 2 bits. It wraps to 0 only via the DONE→IDLE transition, never mid-line.

## Timing
- All outputs are registered.
- Request accepted in cycle T (IDLE, request high):
  - `busy` and the strobe rise at T+1.
  - With `mem_ready` tied high, beats complete at T+1..T+4.
  - The DONE pulse occurs at T+5, and `busy` is high from T+1 to T+5.
  - The FSM is back in IDLE at T+6, and a new request can be accepted at T+6.
- Minimum service is 5 busy cycles per line. Each low cycle of `mem_ready` adds one cycle.
- Write followed by read, both high at T:
  - `wr_done` pulses at T+5.
  - The read is accepted at T+6.
  - `fill_valid` pulses at T+11.
- `fill_line` holds its value after the pulse until the next refill's DONE, or until reset.

## Structure
- Shared package `mips_mem_pkg` holds:
  - the FSM state enum;
  - `LINE_W` = 128, `WORD_W` = 32, `BEATS` = 4;
  - the line-offset constant (4 bits).
- No sub-module is needed: the FSM, beat counter, and line buffer live in one module.

## Test plan
- Read with `rd_addr` = 0x0000_1234 and `mem_ready` = 1:
  - `mem_addr` sequence is 0x1230, 0x1234, 0x1238, 0x123C at T+1..T+4.
  - `mem_rdata` = 0xA0..0xA3 in that order.
  - At T+5, `fill_valid` = 1, `fill_addr` = 0x1230, and `fill_line` = {0xA3,0xA2,0xA1,0xA0}.
- Write with `wr_addr` = 0x80 and `wr_line` = {0xD,0xC,0xB,0xA}:
  - `mem_we` is high for 4 beats.
  - `mem_wdata` sequence is 0xA, 0xB, 0xC, 0xD to addresses 0x80..0x8C.
  - `wr_done` pulses at T+5, and `mem_re` is never high.
- Simultaneous `wr_req` and `rd_req` on the same line:
  - The write beats complete first and `wr_done` pulses at T+5.
  - Then the read runs and `fill_valid` pulses at T+11, returning the written data from the memory model.
- Read with `mem_ready` low for 2 cycles during beat 1:
  - `mem_addr` holds 0x..4 for 3 cycles.
  - `fill_valid` moves to T+7, and `busy` is high for 7 cycles.
- Reset asserted during beat 2 of a read:
  - The next cycle shows IDLE, with `busy`, `mem_re`, and `fill_line` all 0.
  - No `fill_valid` is issued.
  - A request at the following cycle starts cleanly at beat 0.
